// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment scan multiplexer.
package seg_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int IDX_W      = 3;   // enough to address MAX_DIGITS digits

    // All anodes off (active-low).
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    // Active-low one-hot anode pattern for the given digit index.
    function automatic logic [MAX_DIGITS-1:0] onehot_n(input logic [IDX_W-1:0] idx);
        logic [MAX_DIGITS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return ~oh;
    endfunction

endpackage

// File: rtl/seg_refresh_timer.sv
// Refresh divider and digit index for the scan multiplexer.
// tick marks the last cycle of a digit slot; boundary marks the last
// cycle of the last digit slot, i.e. the end of a full frame.
module seg_refresh_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             tick_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             boundary_o
);

    localparam int                 DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Divider wraps every REFRESH_DIV cycles; the digit index steps on each wrap.
    always_comb begin
        tick_o     = (div_cnt_q == DIV_LAST);
        boundary_o = tick_o && (idx_q == IDX_LAST);
        div_cnt_d  = tick_o ? '0 : div_cnt_q + DIV_W'(1);
        idx_d      = idx_q;
        if (tick_o) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner with tear-free word updates.
// A loaded word is parked in a pending register and only becomes visible
// at a frame boundary. Optional leading-zero blanking: SEG_LZ_BLANK_EN.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
    input  logic                          load,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [DIGIT_W-1:0]            nibble,
    output logic                          blank,
    output logic                          dp_n,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic                          frame_done
);

    localparam int               W        = DIGIT_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic             tick, boundary;
    logic [IDX_W-1:0] idx;

    seg_refresh_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .REFRESH_DIV(REFRESH_DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_o    (tick),
        .idx_o     (idx),
        .boundary_o(boundary)
    );

    logic [W-1:0]          disp_word_q, disp_word_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [W-1:0]          pend_word_q, pend_word_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pending_q, pending_d;

    logic [DIGIT_W-1:0]    nibble_q, nibble_d;
    logic                  blank_q, blank_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  frame_done_q, frame_done_d;

    logic [MAX_DIGITS-1:0] an_full;
    logic [NUM_DIGITS-1:0] dp_sh;
`ifdef SEG_LZ_BLANK_EN
    logic [W-1:0]          upper;
`endif

    // Load/pending: loads park in pending; a boundary promotes pending, a load
    // landing exactly on the boundary bypasses pending and wins outright.
    always_comb begin
        disp_word_d = disp_word_q;
        disp_dp_d   = disp_dp_q;
        pend_word_d = pend_word_q;
        pend_dp_d   = pend_dp_q;
        pending_d   = pending_q;
        if (boundary) begin
            if (load) begin
                disp_word_d = value_in;
                disp_dp_d   = dp_in;
                pending_d   = 1'b0;
            end else if (pending_q) begin
                disp_word_d = pend_word_q;
                disp_dp_d   = pend_dp_q;
                pending_d   = 1'b0;
            end
        end else if (load) begin
            pend_word_d = value_in;
            pend_dp_d   = dp_in;
            pending_d   = 1'b1;
        end
    end

    // Display/pending state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_word_q <= '0;
            disp_dp_q   <= '0;
            pend_word_q <= '0;
            pend_dp_q   <= '0;
            pending_q   <= 1'b0;
        end else begin
            disp_word_q <= disp_word_d;
            disp_dp_q   <= disp_dp_d;
            pend_word_q <= pend_word_d;
            pend_dp_q   <= pend_dp_d;
            pending_q   <= pending_d;
        end
    end

    // Per-digit output selection from the current index and displayed word.
    always_comb begin
        an_full      = onehot_n(idx);
        an_n_d       = an_full[NUM_DIGITS-1:0];
        nibble_d     = DIGIT_W'(disp_word_q >> (DIGIT_W * idx));
        dp_sh        = disp_dp_q >> idx;
        dp_n_d       = ~dp_sh[0];
        frame_done_d = tick && (idx == IDX_LAST);
`ifdef SEG_LZ_BLANK_EN
        // Blank a digit when it and everything above it is zero; digit 0 always shows.
        upper        = disp_word_q >> (DIGIT_W * idx);
        blank_d      = (idx != '0) && (upper == '0);
`else
        blank_d      = 1'b0;
`endif
    end

    // Output registers: anode, nibble and dp all switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n_q       <= AN_OFF[NUM_DIGITS-1:0];
            nibble_q     <= '0;
            blank_q      <= 1'b1;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            an_n_q       <= an_n_d;
            nibble_q     <= nibble_d;
            blank_q      <= blank_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an_n       = an_n_q;
    assign nibble     = nibble_q;
    assign blank      = blank_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule
